// File: rtl/radix4_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : radix4_seq_ctrl
//  Purpose  : Control sequencer for a radix-4 Booth multiplier. It walks the
//             multiplier operand two bits per step, emits the Booth triplet
//             and its decoded partial-product controls, and exports the step
//             index (rout) for partial-product weighting.
//  Options  : SEQ_EARLY_EXIT_EN - finish early once every remaining triplet
//             is a zero-op (post-shift operand all-zeros or all-ones).
//  Revision : 1.0 - initial release
// ============================================================================
module radix4_seq_ctrl #(
    parameter int N_BITS = 16,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] mplr_in,
    output logic              busy,
    output logic              done,
    output logic              load_en,
    output logic              clr_acc,
    output logic              step_en,
    output logic [CNT_W-1:0]  rout,
    output logic [2:0]        triplet,
    output logic              pp_zero,
    output logic              pp_two,
    output logic              pp_neg
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_BITS / 2 - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic [1:0]        r_state;
    logic [N_BITS:0]   r_sr;
    logic [CNT_W-1:0]  r_rout;

    logic [N_BITS:0]   w_sr_shift;
    logic              w_run;
    logic              w_zero;
    logic              w_two;
    logic              w_neg;

    // Arithmetic shift by one Booth digit; the sign bit fills the top.
    assign w_sr_shift = {{2{r_sr[N_BITS]}}, r_sr[N_BITS:2]};
    assign w_run      = (r_state == c_RUN);

`ifdef SEQ_EARLY_EXIT_EN
    logic w_tail_idle;
    assign w_tail_idle = (w_sr_shift == '0) || (w_sr_shift == '1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sr    <= '0;
            r_rout  <= c_ZERO;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sr    <= {mplr_in, 1'b0};
                        r_rout  <= c_LAST;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_state <= c_RUN;
                end
                c_RUN: begin
                    r_sr <= w_sr_shift;
                    if (r_rout == c_ZERO) begin
                        r_state <= c_DONE;
`ifdef SEQ_EARLY_EXIT_EN
                    end else if (w_tail_idle) begin
                        // rout is left as-is: weighting stays tied to the step index.
                        r_state <= c_DONE;
`endif
                    end else begin
                        r_rout <= r_rout - c_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_zero = 1'b0;
        w_two  = 1'b0;
        w_neg  = 1'b0;
        case (r_sr[2:0])
            3'b000, 3'b111: w_zero = 1'b1;
            3'b001, 3'b010: w_zero = 1'b0;
            3'b011:         w_two  = 1'b1;
            3'b100: begin
                w_two = 1'b1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: w_neg  = 1'b1;
            default:        w_zero = 1'b0;
        endcase
    end

    assign busy    = (r_state == c_LOAD) || w_run;
    assign done    = (r_state == c_DONE);
    assign load_en = (r_state == c_LOAD);
    assign clr_acc = (r_state == c_LOAD);
    assign step_en = w_run;
    assign rout    = r_rout;
    assign triplet = r_sr[2:0];
    assign pp_zero = w_run & w_zero;
    assign pp_two  = w_run & w_two;
    assign pp_neg  = w_run & w_neg;

endmodule
`default_nettype wire

// File: tb/tb_radix4_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_radix4_seq_ctrl
//  Purpose  : Directed, table-driven bench for radix4_seq_ctrl (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_radix4_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mplr_in;
    logic        busy;
    logic        done;
    logic        load_en;
    logic        clr_acc;
    logic        step_en;
    logic [2:0]  rout;
    logic [2:0]  triplet;
    logic        pp_zero;
    logic        pp_two;
    logic        pp_neg;

    radix4_seq_ctrl #(
        .N_BITS (16),
        .CNT_W  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mplr_in (mplr_in),
        .busy    (busy),
        .done    (done),
        .load_en (load_en),
        .clr_acc (clr_acc),
        .step_en (step_en),
        .rout    (rout),
        .triplet (triplet),
        .pp_zero (pp_zero),
        .pp_two  (pp_two),
        .pp_neg  (pp_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // trips holds the hand-derived triplet of step k in bits [3k+2:3k].
    typedef struct {
        logic [15:0] mplr;
        logic [23:0] trips;
    } vec_t;

    vec_t vecs [6];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {pp_zero, pp_two, pp_neg} for a triplet.
    function automatic logic [2:0] booth_ctl(input logic [2:0] t);
        case (t)
            3'b000, 3'b111: return 3'b100;
            3'b001, 3'b010: return 3'b000;
            3'b011:         return 3'b010;
            3'b100:         return 3'b011;
            default:        return 3'b001;
        endcase
    endfunction

    // Launch one multiply from IDLE and check every cycle through DONE.
    task automatic do_op(input vec_t v, input bit hold_start);
        int          sum;
        int          mag;
        logic [2:0]  exp_t;
        mplr_in = v.mplr;
        start   = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        check("load_ctl", 32'({load_en, clr_acc, busy, step_en, done}), 32'b11100);
        sum = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_t = v.trips[3*k +: 3];
            check("run_ctl", 32'({busy, step_en, done, load_en}), 32'b1100);
            check("rout", 32'(rout), 32'(7 - k));
            check("triplet", 32'(triplet), 32'(exp_t));
            check("decode", 32'({pp_zero, pp_two, pp_neg}), 32'(booth_ctl(exp_t)));
            mag = pp_zero ? 0 : (pp_two ? 2 : 1);
            if (pp_neg) mag = -mag;
            sum = sum + mag * (1 << (2 * (7 - int'(rout))));
        end
        @(negedge clk);
        check("done_cycle", 32'({done, busy, step_en}), 32'b100);
        check("done_rout", 32'(rout), 32'd0);
        check("weight_sum", 32'(sum), 32'(int'($signed(v.mplr))));
    endtask

    initial begin
        int seen_done;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mplr_in = 16'h0000;

        vecs[0] = '{mplr: 16'h0003, trips: 24'h00000E};
        vecs[1] = '{mplr: 16'hFFFF, trips: 24'hFFFFFE};
        vecs[2] = '{mplr: 16'h8000, trips: 24'h800000};
        vecs[3] = '{mplr: 16'h5A5A, trips: 24'h4EC4EC};
        vecs[4] = '{mplr: 16'h0000, trips: 24'h000000};
        vecs[5] = '{mplr: 16'h7FFF, trips: 24'h7FFFFE};

        repeat (3) @(negedge clk);
        check("reset_ctl", 32'({busy, done, load_en, clr_acc, step_en}), 32'd0);
        check("reset_rout", 32'(rout), 32'd0);
        check("reset_trip", 32'(triplet), 32'd0);
        check("reset_pp", 32'({pp_zero, pp_two, pp_neg}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctl", 32'({busy, done, load_en}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i], 1'b0);
            @(negedge clk);
            check("post_idle", 32'({busy, done, load_en, step_en}), 32'd0);
        end

        // start held through an op: the DONE-cycle start is dropped, IDLE picks it up.
        do_op(vecs[3], 1'b1);
        @(negedge clk);
        check("held_idle", 32'({busy, done, load_en, clr_acc}), 32'd0);
        do_op(vecs[3], 1'b0);
        @(negedge clk);
        check("held_end_idle", 32'({busy, done, load_en}), 32'd0);

        // Abort mid-RUN at rout=4.
        mplr_in = 16'h0003;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre_rout", 32'(rout), 32'd4);
        check("abort_pre_step", 32'(step_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctl", 32'({busy, done, step_en, load_en}), 32'd0);
        check("abort_rout", 32'(rout), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("abort_quiet", 32'(seen_done), 32'd0);
        do_op(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
